// File: rtl/seed_loader_if.sv
// Board RAM row-write port: one row of cells per valid/ready handshake.
interface seed_loader_if #(
    parameter int unsigned W = 16,
    parameter int unsigned H = 16
);
    localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;

    logic          wr_valid;
    logic          wr_ready;
    logic [RW-1:0] wr_row;
    logic [W-1:0]  wr_data;

    // Loader side presents the write, memory side accepts it.
    modport master (output wr_valid, output wr_row, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_row, input wr_data, output wr_ready);
endinterface

// File: rtl/seed_loader.sv
// Copies a snapshotted seed into the life board one row per write handshake,
// holding the generation engine and counting live cells as rows are accepted.
module seed_loader #(
    parameter int unsigned W      = 16,
    parameter int unsigned H      = 16,
    parameter int unsigned SEED_W = W * H,
    localparam int unsigned RW    = (H > 1) ? $clog2(H) : 1,
    localparam int unsigned PW    = $clog2(SEED_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SEED_W-1:0] seed_i,
    seed_loader_if.master     wr,
    output logic              busy_o,
    output logic              gen_hold_o,
    output logic              done_o,
    output logic [PW-1:0]     population_o,
    output logic              zero_seed_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [SEED_W-1:0] snap_q;
    logic [RW-1:0]     row_q;
    logic [RW-1:0]     row_d;
    logic              wr_valid_q;
    logic [W-1:0]      wr_data_q;
    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     population_q;
    logic              zero_seed_q;

    // Number of live cells in one row.
    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(W); i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    assign row_d = row_q + RW'(1);

    // Load sequencer: capture seed, stream rows, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            row_q        <= '0;
            wr_valid_q   <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            population_q <= '0;
            zero_seed_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        snap_q       <= seed_i;
                        row_q        <= '0;
                        wr_valid_q   <= 1'b1;
                        wr_data_q    <= seed_i[W-1:0];
                        busy_q       <= 1'b1;
                        population_q <= '0;
                        zero_seed_q  <= (seed_i == '0);
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // A presented write stays put until the memory takes it.
                    if (wr_valid_q && wr.wr_ready) begin
                        population_q <= population_q + popcount(wr_data_q);
                        if (row_q == RW'(H - 1)) begin
                            wr_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            row_q     <= row_d;
                            wr_data_q <= snap_q[32'(row_d) * W +: W];
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    wr_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign wr.wr_valid   = wr_valid_q;
    assign wr.wr_row     = row_q;
    assign wr.wr_data    = wr_data_q;
    assign busy_o        = busy_q;
    assign gen_hold_o    = busy_q;
    assign done_o        = done_q;
    assign population_o  = population_q;
    assign zero_seed_o   = zero_seed_q;

endmodule
